seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for the 8-digit seven-segment display. It holds one 4-bit value per digit and steps the shared hex-to-segment decoder through the digits, driving its `num`/`sel` inputs. It provides a blanking guard interval between digits to suppress ghosting, and a per-digit enable. It sits between the register-write source (switches/CPU) and the combinational decoder, whose `seg`/`an` outputs go to the board pins.

## Interface
- `DWELL`, default 50000: cycles each digit is shown (≥1).
- `GUARD`, default 500: blanked cycles between digits (≥0; 0 = no guard).
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  scan enable; 0 = display off.
- `wr_en`  in  1  write strobe for digit register file.
- `wr_addr`  in  3  digit index to write.
- `wr_data`  in  4  hex value to store.
- `digit_en`  in  8  per-digit enable; bit i = 0 blanks digit i.
- `num`  out  4  value to decoder (= digit_reg[sel]).
- `sel`  out  3  digit select to decoder.
- `blank`  out  1  1 = downstream forces all anodes off.
- `frame_tick`  out  1  one-cycle pulse at start of each frame.

## Operation
- **Reset:** state OFF; all 8 digit registers = 0; timer = 0; `sel`=0; `num`=0; `blank`=1; `frame_tick`=0. Reset mid-scan aborts immediately; no write completes in the reset cycle.
- **Register file:** 8×4 flops. `wr_en`=1 stores `wr_data` at `wr_addr` on the edge. Writes are accepted in every state, including OFF. `num` is a combinational read of `digit_reg[sel]` from flops, so it is glitch-free at board scale.
- **State machine:**
  - OFF → SHOW when `en`=1. On entry, `sel`=0 and the timer is cleared.
  - SHOW → GUARD after DWELL cycles. If GUARD=0, SHOW goes directly to SHOW of the next digit.
  - GUARD → SHOW after GUARD cycles. `sel` increments on the GUARD→SHOW edge and wraps 7→0.
  - Any state → OFF when `en`=0. This is sampled every cycle, and `sel` is reset to 0.
- **`blank`:** 1 in OFF and GUARD. In SHOW, `blank` = ~`digit_en[sel]`. `digit_en` is used live, with no sampling.
- **`frame_tick`:** asserted for exactly the first SHOW cycle with `sel`=0. This includes the first cycle after entry from OFF.
- **Timer:** width `$clog2(max(DWELL,GUARD)+1)`. It counts 0..DWELL-1 in SHOW and 0..GUARD-1 in GUARD, and clears on every state change.
- **Simultaneous events:**
  - A write to the displayed digit changes `num` on the cycle after the write edge.
  - `en` falling on a digit boundary: OFF wins.
  - `wr_en` together with `rst_n`=0: reset wins.

## Timing
- All outputs are registered state or combinational from flops. There is no input-to-output combinational path except `digit_en`→`blank`.
- `en` sampled 1 at edge t: in cycle t+1, state=SHOW, `sel`=0, `frame_tick`=1.
- Digit period is DWELL+GUARD cycles. Frame period is 8·(DWELL+GUARD) cycles, so `frame_tick` repeats at that period.
- `en` sampled 0 at edge t: in cycle t+1, `blank`=1 and `sel`=0.
- Write latency: `wr_en` at edge t, new value visible on `num` from cycle t+1 if `sel`==`wr_addr`.

## Structure
- Shared package `seg_pkg`:
  - `N_DIGITS`=8, `DIGIT_W`=4, `SEL_W`=3.
  - `typedef enum logic [1:0] {OFF, SHOW, GUARD} scan_state_e`.
- One sub-module, `seg_dwell_timer`: a loadable down/up counter with clear and a `done` output, parameterised by width. The FSM and register file stay in `seg_scan_ctrl`.
- The decoder is instantiated by the top level, not inside this block.

## Test plan
All scenarios use DWELL=4, GUARD=1 (digit period 5, frame 40).

- **Reset/idle:** `rst_n`=0 for 2 cycles, then `en`=0 for 10 cycles → `blank`=1, `sel`=0, `num`=0, `frame_tick`=0 throughout.
- **Full scan:**
  - Stimulus: write digits 0..7 = 0x1,0x3,0x5,0x7,0x9,0xB,0xD,0xF; then `en`=1.
  - `sel`: holds each index for exactly 5 cycles, with `blank`=0 for 4 and `blank`=1 for 1.
  - `num` follows the written values.
  - `frame_tick` pulses once per 40 cycles.
  - Wrap 7→0 is observed.
- **Digit blanking:** `digit_en`=8'b1011_1110 → `blank`=1 during all SHOW cycles of `sel`=0 and `sel`=6; other digits are unaffected.
- **Live write:** while `sel`=3 in SHOW, write addr 3 = 0xA → `num`=0xA from the next cycle. A write to addr 5 in the same window leaves `num` unchanged until `sel`=5.
- **Enable/reset mid-scan:**
  - `en`→0 while `sel`=4 → next cycle `blank`=1, `sel`=0. Re-enable → `frame_tick` on the first SHOW cycle.
  - `rst_n`=0 mid-GUARD → all outputs at reset values next cycle, and the registers read 0.
- **GUARD=0 variant:** `blank` never rises while all `digit_en`=1; digit period = 4 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared sizes and scan state type for the seven-segment scan controller
package seg_pkg;
  localparam int N_DIGITS = 8;
  localparam int DIGIT_W  = 4;
  localparam int SEL_W    = 3;
  typedef enum logic [1:0] {OFF, SHOW, GUARD} scan_state_e;
endpackage

// File: rtl/seg_dwell_timer.sv
// seg_dwell_timer: loadable up/down counter with clear and terminal-count flag
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_clr zeroes the count;
// i_load/i_load_val preset; i_cnt_en/i_dn step direction; o_done = (count == i_term).
module seg_dwell_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_cnt_en,
  input  logic         i_dn,
  input  logic [W-1:0] i_term,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  assign o_done = r_cnt == i_term;
  always_ff @(posedge i_clk)
    if (!i_rst_n || i_clr) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_cnt_en) r_cnt <= i_dn ? r_cnt - 1'b1 : r_cnt + 1'b1;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 8-digit scan with guard blanking and per-digit enable
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_en scan enable;
// i_wr_en/i_wr_addr/i_wr_data digit register write; i_digit_en per-digit enable;
// o_num/o_sel decoder value and select; o_blank anode-off request; o_frame_tick frame start pulse.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_wr_en,
  input  logic [SEL_W-1:0]   i_wr_addr,
  input  logic [DIGIT_W-1:0] i_wr_data,
  input  logic [N_DIGITS-1:0] i_digit_en,
  output logic [DIGIT_W-1:0] o_num,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_blank,
  output logic               o_frame_tick
);
  localparam int TW = $clog2((DWELL > GUARD ? DWELL : GUARD) + 1);
  localparam logic [TW-1:0] D_TERM = TW'(DWELL - 1);
  localparam logic [TW-1:0] G_TERM = TW'((GUARD > 0 ? GUARD : 1) - 1);
  scan_state_e r_state;
  logic [SEL_W-1:0] r_sel;
  logic r_frame_tick;
  logic [DIGIT_W-1:0] r_digit [N_DIGITS];
  logic w_tdone, w_done, w_clr, w_last;
  logic [TW-1:0] w_term;
  assign w_term  = r_state == seg_pkg::GUARD ? G_TERM : D_TERM;
  assign w_done  = w_tdone && r_state != OFF;
  // timer restarts on every state or digit change, and stays parked at 0 while off
  assign w_clr   = !i_en || r_state == OFF || w_done;
  assign w_last  = r_sel == SEL_W'(N_DIGITS - 1);
  seg_dwell_timer #(.W(TW)) u_timer (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_clr(w_clr),
    .i_load(1'b0),
    .i_load_val('0),
    .i_cnt_en(1'b1),
    .i_dn(1'b0),
    .i_term(w_term),
    .o_done(w_tdone)
  );
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_state      <= OFF;
      r_sel        <= '0;
      r_frame_tick <= 1'b0;
    end else if (!i_en) begin
      r_state      <= OFF;
      r_sel        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      case (r_state)
        OFF: begin
          r_state      <= SHOW;
          r_sel        <= '0;
          r_frame_tick <= 1'b1;
        end
        SHOW:
          if (w_done) begin
            if (GUARD == 0) begin
              r_sel        <= r_sel + 1'b1;
              r_frame_tick <= w_last;
            end else r_state <= seg_pkg::GUARD;
          end
        seg_pkg::GUARD:
          if (w_done) begin
            r_state      <= SHOW;
            r_sel        <= r_sel + 1'b1;
            r_frame_tick <= w_last;
          end
        default: r_state <= OFF;
      endcase
    end
  always_ff @(posedge i_clk)
    if (!i_rst_n) for (int k = 0; k < N_DIGITS; k++) r_digit[k] <= '0;
    else if (i_wr_en) r_digit[i_wr_addr] <= i_wr_data;
  assign o_num        = r_digit[r_sel];
  assign o_sel        = r_sel;
  assign o_blank      = r_state != SHOW || !i_digit_en[r_sel];
  assign o_frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: vector table, directed corner cases and random stimulus against a timeline model
module tb_seg_scan_ctrl;
  localparam int DW = 4;
  localparam int P  = 5;
  localparam int P0 = 4;
  logic clk = 0, rst_n = 0, en = 0, wr_en = 0;
  logic [2:0] wr_addr = 0;
  logic [3:0] wr_data = 0;
  logic [7:0] digit_en = 8'hff;
  logic [3:0] num, num0;
  logic [2:0] sel, sel0;
  logic blank, blank0, tick, tick0;
  int checks = 0, errors = 0;
  logic [3:0] mem [8];
  int t = -1;
  typedef struct {
    logic rst_n, en, wr_en;
    logic [2:0] addr;
    logic [3:0] data;
    logic [7:0] den;
    logic [2:0] sel;
    logic [3:0] num;
    logic blank, tick;
  } vec_t;
  vec_t tv [12];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DWELL(DW), .GUARD(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_digit_en(digit_en), .o_num(num), .o_sel(sel),
    .o_blank(blank), .o_frame_tick(tick));
  seg_scan_ctrl #(.DWELL(DW), .GUARD(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_digit_en(digit_en), .o_num(num0), .o_sel(sel0),
    .o_blank(blank0), .o_frame_tick(tick0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // t = cycles since the first SHOW cycle after enable, -1 while off
  function automatic int m_sel(int p);
    return t < 0 ? 0 : (t / p) % 8;
  endfunction
  function automatic logic m_blank(int p);
    return t < 0 || (t % p) >= DW || !digit_en[m_sel(p)];
  endfunction
  function automatic logic m_tick(int p);
    return t >= 0 && t % (8 * p) == 0;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      t = -1;
      foreach (mem[i]) mem[i] = 0;
    end else begin
      if (wr_en) mem[wr_addr] = wr_data;
      t = en ? t + 1 : -1;
    end
    #1;
    chk("sel", sel, m_sel(P));
    chk("num", num, mem[m_sel(P)]);
    chk("blank", blank, m_blank(P));
    chk("tick", tick, m_tick(P));
    chk("g0_sel", sel0, m_sel(P0));
    chk("g0_num", num0, mem[m_sel(P0)]);
    chk("g0_blank", blank0, m_blank(P0));
    chk("g0_tick", tick0, m_tick(P0));
  endtask

  task automatic wait_show(input logic [2:0] s, input string nm);
    int n = 0;
    while (!(sel == s && !blank) && n < 100) begin
      step();
      n++;
    end
    chk({nm, "_timeout"}, n < 100, 1);
  endtask

  initial begin
    int prev, run, last, wraps;
    foreach (mem[i]) mem[i] = 0;
    tv[0]  = '{0, 0, 0, 0, 0, 8'hff, 0, 0, 1, 0};
    tv[1]  = '{0, 0, 1, 0, 5, 8'hff, 0, 0, 1, 0};
    tv[2]  = '{1, 0, 0, 0, 0, 8'hff, 0, 0, 1, 0};
    tv[3]  = '{1, 0, 1, 0, 6, 8'hff, 0, 6, 1, 0};
    tv[4]  = '{1, 1, 0, 0, 0, 8'hff, 0, 6, 0, 1};
    tv[5]  = '{1, 1, 0, 0, 0, 8'hff, 0, 6, 0, 0};
    tv[6]  = '{1, 1, 1, 0, 9, 8'hff, 0, 9, 0, 0};
    tv[7]  = '{1, 1, 0, 0, 0, 8'hfe, 0, 9, 1, 0};
    tv[8]  = '{1, 1, 0, 0, 0, 8'hff, 0, 9, 1, 0};
    tv[9]  = '{1, 1, 0, 0, 0, 8'hff, 1, 0, 0, 0};
    tv[10] = '{1, 0, 0, 0, 0, 8'hff, 0, 9, 1, 0};
    tv[11] = '{1, 1, 0, 0, 0, 8'hff, 0, 9, 0, 1};
    for (int i = 0; i < 12; i++) begin
      rst_n = tv[i].rst_n; en = tv[i].en; wr_en = tv[i].wr_en;
      wr_addr = tv[i].addr; wr_data = tv[i].data; digit_en = tv[i].den;
      step();
      chk("tv_sel", sel, tv[i].sel);
      chk("tv_num", num, tv[i].num);
      chk("tv_blank", blank, tv[i].blank);
      chk("tv_tick", tick, tv[i].tick);
    end
    wr_en = 0; digit_en = 8'hff;
    rst_n = 0; en = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (10) begin
      step();
      chk("idle_blank", blank, 1);
      chk("idle_sel", sel, 0);
      chk("idle_num", num, 0);
      chk("idle_tick", tick, 0);
    end
    for (int a = 0; a < 8; a++) begin
      wr_en = 1; wr_addr = 3'(a); wr_data = 4'(2 * a + 1);
      step();
    end
    wr_en = 0; en = 1;
    prev = -1; run = 0; last = -1; wraps = 0;
    for (int c = 0; c < 90; c++) begin
      step();
      chk("scan_g0_noblank", blank0, 0);
      if (tick) begin
        if (last >= 0) chk("frame_period", c - last, 40);
        last = c;
      end
      if (int'(sel) == prev) run++;
      else begin
        if (prev >= 0) begin
          chk("sel_hold", run, 5);
          if (prev == 7 && sel == 0) wraps++;
        end
        prev = int'(sel);
        run = 1;
      end
    end
    chk("wrap_seen", wraps > 0, 1);
    digit_en = 8'b1011_1110;
    repeat (40) begin
      step();
      if (sel == 0 || sel == 6) chk("den_blank", blank, 1);
    end
    digit_en = 8'hff;
    wait_show(3, "live3");
    wr_en = 1; wr_addr = 3; wr_data = 4'hA;
    step();
    chk("live_num", num, 4'hA);
    wr_addr = 5; wr_data = 4'hC;
    step();
    wr_en = 0;
    chk("other_write_num", num, 4'hA);
    wait_show(5, "live5");
    chk("addr5_num", num, 4'hC);
    wait_show(4, "mid4");
    en = 0;
    step();
    chk("off_blank", blank, 1);
    chk("off_sel", sel, 0);
    en = 1;
    step();
    chk("reen_tick", tick, 1);
    wait_show(2, "guard2");
    repeat (4) step();
    chk("in_guard", blank, 1);
    rst_n = 0;
    step();
    chk("rst_sel", sel, 0);
    chk("rst_num", num, 0);
    chk("rst_blank", blank, 1);
    chk("rst_tick", tick, 0);
    rst_n = 1;
    repeat (40) begin
      step();
      chk("cleared_num", num, 0);
    end
    repeat (1500) begin
      rst_n = $urandom_range(0, 99) != 0;
      en = $urandom_range(0, 29) != 0;
      wr_en = $urandom_range(0, 3) == 0;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      digit_en = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hff;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
